// File: rtl/fma_pkg.sv
// Shared definitions for the FMA round/pack back end: binary32 field layout,
// flag bit positions and the record carried from the normalize to the round stage.
package fma_pkg;

    localparam int BIAS     = 127;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_MAX  = 2 * BIAS + 1;
    localparam int E_W      = 11;

    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_INX = 0;

    typedef struct packed {
        logic             sign;
        logic             zero;
        logic [E_W-1:0]   e;
        logic [MAN_W-1:0] mant;
        logic             guard;
        logic             sticky;
    } s1_t;

endpackage

// File: rtl/fma_lzc.sv
// Combinational leading-zero counter; out_cnt is the left shift that brings the
// leading one to the MSB (0 when the vector is all zeros, flagged by out_zero).
module fma_lzc #(
    parameter int W     = 50,
    parameter int CNT_W = $clog2(W)
) (
    input  logic [W-1:0]     in_vec,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_zero
);

    always_comb begin
        out_cnt = '0;
        for (int i = 0; i < W; i++) begin
            if (in_vec[i]) out_cnt = CNT_W'(W - 1 - i);
        end
    end

    assign out_zero = ~|in_vec;

endmodule

// File: rtl/fma_round_pack.sv
// FMA back end: normalize (S1) then round-to-nearest-even and pack to binary32 (S2).
// Define FMA_ROUND_PACK_SUBNORMAL_EN to produce subnormal results instead of flushing to zero.
module fma_round_pack
    import fma_pkg::*;
#(
    parameter int SUM_W = 50,
    parameter int POINT = 46
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [9:0]       in_exp,
    input  logic [SUM_W-1:0] in_sum,
    input  logic             in_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags
);

    localparam int LZ_W = $clog2(SUM_W);

    function automatic logic [MAN_W:0] f_rne(input logic [MAN_W-1:0] mant,
                                             input logic guard, input logic sticky);
        return {1'b0, mant} + (MAN_W+1)'(guard & (sticky | mant[0]));
    endfunction

`ifdef FMA_ROUND_PACK_SUBNORMAL_EN
    // Returns {mantissa, guard, sticky} after shifting the hidden-bit significand right by sh.
    function automatic logic [MAN_W+1:0] f_denorm(input logic [MAN_W-1:0] mant,
                                                  input logic guard, input logic sticky,
                                                  input logic [E_W:0] sh);
        logic [MAN_W+1:0] v;
        logic [MAN_W+1:0] mask;
        logic [MAN_W:0]   sh_v;
        v = {1'b1, mant, guard};
        if (sh >= (E_W+1)'(MAN_W + 2)) return {{MAN_W{1'b0}}, 1'b0, 1'b1};
        mask = ~({(MAN_W+2){1'b1}} << sh[4:0]);
        sh_v = (MAN_W+1)'(v >> sh[4:0]);
        return {sh_v[MAN_W:1], sh_v[0], sticky | (|(v & mask))};
    endfunction
`endif

    logic             r_s1_vld;
    s1_t              r_s1;
    logic             r_s2_vld;
    logic [31:0]      r_result;
    logic [2:0]       r_flags;

    logic             w_s2_free;
    logic             w_s1_free;
    logic [LZ_W-1:0]  w_lzc;
    logic             w_zero;
    logic [SUM_W-2:0] w_norm;
    s1_t              w_s1_next;

    logic signed [E_W:0] w_e2;
    logic signed [E_W:0] w_e_rnd;
    logic [MAN_W:0]      w_rnd;
    logic [31:0]         w_pk_res;
    logic [2:0]          w_pk_flags;
`ifdef FMA_ROUND_PACK_SUBNORMAL_EN
    logic [MAN_W+1:0]    w_dn;
`endif

    assign w_s2_free = !r_s2_vld || out_ready;
    assign w_s1_free = !r_s1_vld || w_s2_free;
    assign in_ready  = !rst && w_s1_free;

    // ---- S1: leading-one detect and normalize ----
    fma_lzc #(.W(SUM_W), .CNT_W(LZ_W)) u_lzc (
        .in_vec   (in_sum),
        .out_cnt  (w_lzc),
        .out_zero (w_zero)
    );

    // The leading one lands on the dropped MSB, so it stays implicit.
    assign w_norm = (SUM_W-1)'(in_sum << w_lzc);

    always_comb begin
        w_s1_next.sign   = in_sign;
        w_s1_next.zero   = w_zero;
        w_s1_next.e      = {in_exp[9], in_exp} + E_W'(SUM_W - 1 - POINT) - E_W'(w_lzc);
        w_s1_next.mant   = w_norm[SUM_W-2 -: MAN_W];
        w_s1_next.guard  = w_norm[SUM_W-2-MAN_W];
        w_s1_next.sticky = (|w_norm[SUM_W-3-MAN_W:0]) | in_sticky;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
        end else if (w_s1_free) begin
            r_s1_vld <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_free && in_valid) r_s1 <= w_s1_next;
    end

    // ---- S2: round to nearest even and pack ----
    assign w_e2 = $signed({r_s1.e[E_W-1], r_s1.e});

    always_comb begin
        w_pk_res   = '0;
        w_pk_flags = '0;
        w_rnd      = '0;
        w_e_rnd    = '0;
`ifdef FMA_ROUND_PACK_SUBNORMAL_EN
        w_dn       = '0;
`endif
        if (r_s1.zero) begin
            w_pk_res             = {r_s1.sign, 31'b0};
            w_pk_flags[FLAG_UNF] = r_s1.sticky;
            w_pk_flags[FLAG_INX] = r_s1.sticky;
        end else if (w_e2 <= 12'sd0) begin
`ifdef FMA_ROUND_PACK_SUBNORMAL_EN
            w_dn  = f_denorm(r_s1.mant, r_s1.guard, r_s1.sticky, 12'sd1 - w_e2);
            w_rnd = f_rne(w_dn[MAN_W+1:2], w_dn[1], w_dn[0]);
            // A carry into bit 23 becomes exponent field 1, the smallest normal.
            w_pk_res             = {r_s1.sign, 7'b0, w_rnd};
            w_pk_flags[FLAG_UNF] = w_dn[1] | w_dn[0];
            w_pk_flags[FLAG_INX] = w_dn[1] | w_dn[0];
`else
            w_pk_res             = {r_s1.sign, 31'b0};
            w_pk_flags[FLAG_UNF] = 1'b1;
            w_pk_flags[FLAG_INX] = 1'b1;
`endif
        end else begin
            w_rnd   = f_rne(r_s1.mant, r_s1.guard, r_s1.sticky);
            w_e_rnd = w_e2 + $signed({{E_W{1'b0}}, w_rnd[MAN_W]});
            if (w_e_rnd >= (E_W+1)'(EXP_MAX)) begin
                w_pk_res             = {r_s1.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                w_pk_flags[FLAG_OVF] = 1'b1;
                w_pk_flags[FLAG_INX] = 1'b1;
            end else begin
                w_pk_res             = {r_s1.sign, w_e_rnd[EXP_W-1:0], w_rnd[MAN_W-1:0]};
                w_pk_flags[FLAG_INX] = r_s1.guard | r_s1.sticky;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_s2_free) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_result <= w_pk_res;
                r_flags  <= w_pk_flags;
            end
        end
    end

    assign out_valid  = r_s2_vld;
    assign out_result = r_result;
    assign out_flags  = r_flags;

endmodule

// File: tb/tb_fma_round_pack.sv
// Bench for fma_round_pack: arithmetic reference model plus scoreboard, directed vectors,
// stall, reset and randomized-handshake phases. Honors FMA_ROUND_PACK_SUBNORMAL_EN.
module tb_fma_round_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [49:0] in_sum = '0;
    logic        in_sticky = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    int          nchk = 0;
    int          nfail = 0;
    logic [34:0] expq[$];
    int          acc_cnt = 0;
    int          drop_at = -1;
    logic        held_v = 1'b0;
    logic [31:0] held_r = '0;
    logic [2:0]  held_f = '0;

    always #5 clk = ~clk;

    fma_round_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sum     (in_sum),
        .in_sticky  (in_sticky),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: value = sum * 2^(exp-127-46); choose the binary32 quantum, split the sum
    // into kept quotient and remainder, and round to nearest even on the integers.
    function automatic logic [34:0] model(input logic s, input logic signed [9:0] ex,
                                          input logic [49:0] sm, input logic st);
        int     p;
        int     e;
        int     ulp;
        longint q;
        longint rem;
        longint half;
        logic   up;
        logic   inx;
        if (sm == 0) return {1'b0, st, st, s, 31'b0};
        p = 49;
        while (p > 0 && !sm[p]) p--;
        e = int'(ex) + p - 46;
`ifndef FMA_ROUND_PACK_SUBNORMAL_EN
        if (e <= 0) return {3'b011, s, 31'b0};
`endif
        ulp = p - 23 + ((e < 1) ? (1 - e) : 0);
        up = 1'b0;
        if (ulp > 60) begin
            q = 0;
            inx = 1'b1;
        end else if (ulp <= 0) begin
            q = longint'(sm) << (-ulp);
            inx = st;
        end else begin
            q    = longint'(sm) >> ulp;
            rem  = longint'(sm) & ((longint'(1) << ulp) - 1);
            half = longint'(1) << (ulp - 1);
            inx  = (rem != 0) || st;
            up   = (rem > half) || (rem == half && (st || q[0]));
        end
        q = q + longint'(up);
        if (e >= 1) begin
            if (q == (longint'(1) << 24)) begin
                e++;
                q = longint'(1) << 23;
            end
            if (e >= 255) return {3'b101, s, 8'hFF, 23'b0};
            return {2'b00, inx, s, e[7:0], q[22:0]};
        end
        return {1'b0, inx, inx, s, q[30:0]};
    endfunction

    task automatic send(input logic s, input logic [9:0] ex, input logic [49:0] sm, input logic st);
        bit done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_sign = s; in_exp = ex; in_sum = sm; in_sticky = st;
        for (int t = 0; t < 100 && !done; t++) begin
            #4;
            if (in_ready) begin
                expq.push_back(model(s, ex, sm, st));
                acc_cnt++;
                done = 1'b1;
                @(posedge clk);
            end else begin
                if (drop_at < 0) drop_at = acc_cnt;
                @(negedge clk);
            end
        end
        if (!done) begin
            nchk++; nfail++;
            $display("FAIL send_timeout: in_ready stayed %0b, expected 1", in_ready);
        end
    endtask

    task automatic lit(input string name, input logic s, input logic [9:0] ex, input logic [49:0] sm,
                       input logic st, input logic [31:0] er, input logic [2:0] ef);
        check({name, "_model"}, 64'(model(s, ex, sm, st)), 64'({ef, er}));
        repeat (3) @(negedge clk);
        send(s, ex, sm, st);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({name, "_lat1"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        #1 check({name, "_lat2"}, 64'({out_valid, out_flags, out_result}), 64'({1'b1, ef, er}));
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 100 && expq.size() != 0; t++) @(negedge clk);
        check(name, 64'(expq.size()), 64'(0));
    endtask

    // Scoreboard compare just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        if (rst) begin
            check("reset_outs", 64'({in_ready, out_valid, out_result, out_flags}), 64'(0));
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("hold", 64'({out_valid, out_result, out_flags}), 64'({1'b1, held_r, held_f}));
            if (out_valid) begin
                if (expq.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL spurious_out: out_valid=1 result %0h, expected no output", out_result);
                end else begin
                    check("result", 64'({out_flags, out_result}), 64'(expq[0]));
                    if (out_ready) void'(expq.pop_front());
                end
            end
            held_v = out_valid && !out_ready;
            held_r = out_result;
            held_f = out_flags;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rdone;
        logic [49:0] r_sm;
        logic [9:0]  r_ex;
        logic        r_st;

        repeat (3) @(negedge clk);
        #1 check("reset_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        lit("one",      1'b0, 10'd127, 50'd1 << 46, 1'b0, 32'h3F800000, 3'b000);
        lit("tie_even", 1'b0, 10'd127, (50'd1 << 46) | (50'd1 << 22), 1'b0, 32'h3F800000, 3'b001);
        lit("tie_odd",  1'b0, 10'd127, (50'd1 << 46) | (50'd1 << 23) | (50'd1 << 22), 1'b0,
            32'h3F800002, 3'b001);
        lit("tie_stk",  1'b0, 10'd127, (50'd1 << 46) | (50'd1 << 22), 1'b1, 32'h3F800001, 3'b001);
        lit("carry",    1'b0, 10'd127, (50'd1 << 47) - 50'd1, 1'b0, 32'h40000000, 3'b001);
        lit("shifted",  1'b0, 10'd130, 50'd1 << 40, 1'b0, 32'h3E000000, 3'b000);
        lit("ovf_pos",  1'b0, 10'd254, 50'd1 << 48, 1'b0, 32'h7F800000, 3'b101);
        lit("ovf_neg",  1'b1, 10'd254, 50'd1 << 48, 1'b0, 32'hFF800000, 3'b101);
        lit("zero",     1'b1, 10'd100, 50'd0, 1'b0, 32'h80000000, 3'b000);
`ifdef FMA_ROUND_PACK_SUBNORMAL_EN
        lit("tiny",     1'b0, 10'd1, 50'd1 << 45, 1'b0, 32'h00400000, 3'b000);
`else
        lit("tiny",     1'b0, 10'd1, 50'd1 << 45, 1'b0, 32'h00000000, 3'b011);
`endif

        // Stall: out_ready low while four inputs are offered back to back.
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        acc_cnt = 0;
        drop_at = -1;
        fork
            begin
                send(1'b0, 10'd127, 50'd1 << 46, 1'b0);
                send(1'b1, 10'd128, 50'd1 << 46, 1'b0);
                send(1'b0, 10'd126, 50'd3 << 45, 1'b0);
                send(1'b1, 10'd140, (50'd1 << 46) | 50'd12345, 1'b1);
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        check("stall_drop_after", 64'(drop_at), 64'(2));
        drain("stall_drain");

        // Reset with both stages occupied.
        @(negedge clk);
        out_ready = 1'b0;
        send(1'b0, 10'd127, 50'd1 << 46, 1'b0);
        send(1'b0, 10'd128, 50'd1 << 46, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        expq.delete();
        #1 check("rst_async", 64'({out_valid, in_ready}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #4 check("rst_first_accept", 64'(in_ready), 64'(1));
        repeat (4) @(negedge clk);
        #1 check("rst_no_stale", 64'(out_valid), 64'(0));

        // Mixed traffic with random downstream back-pressure.
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 30; k++) begin
                    r_sm = 50'({$urandom(), $urandom()}) >> $urandom_range(0, 49);
                    r_ex = 10'($urandom_range(0, 320)) - 10'd40;
                    r_st = (r_sm != 0) && ($urandom_range(0, 1) == 1);
                    send(1'($urandom_range(0, 1)), r_ex, r_sm, r_st);
                end
                @(negedge clk);
                in_valid = 1'b0;
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("random_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/fma_round_pack.md
FMA_ROUND_PACK -- requirements
Module: fma_round_pack

Interface
REQ-001 SUM_W, 50, width of unsigned magnitude input in_sum.
REQ-002 POINT, 46, bit index of in_sum with weight 2^0 at exponent in_exp.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream (FMA adder stage) result valid.
REQ-006 in_ready  output  1  block can accept input this cycle.
REQ-007 in_sign  input  1  sign of the unrounded sum.
REQ-008 in_exp  input  10  signed biased exponent (bias 127) for bit POINT.
REQ-009 in_sum  input  SUM_W  unsigned magnitude; value = (-1)^in_sign * in_sum * 2^(in_exp-127-POINT).
REQ-010 in_sticky  input  1  OR of bits already discarded upstream.
REQ-011 out_valid  output  1  packed result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_result  output  32  IEEE-754 binary32 result.
REQ-014 out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-015 Transfer occurs when valid and ready both high on a clock edge; no other event moves data.
REQ-016 Two register stages: S1 = leading-one detect + normalize shift; S2 = round-to-nearest-even + pack.
REQ-017 Latency: accepted input appears on out_result exactly 2 cycles later when out_ready held high; throughput 1 per cycle.
REQ-018 Each stage loads when empty or its content is leaving the same cycle; in_ready = !S1_valid || S1 advancing, combinationally from out_ready.
REQ-019 Under out_ready low, no input is lost, duplicated or reordered; outputs hold stable while out_valid && !out_ready.
REQ-020 S1: p = index of leading one in in_sum; e = in_exp + p - POINT (11-bit signed); mantissa = 23 bits below leading one; guard = next bit; sticky = OR of remaining bits | in_sticky.
REQ-021 S2: round up iff guard && (sticky || mantissa LSB); mantissa carry-out sets e = e+1 and mantissa 0.
REQ-022 e >= 255 after rounding: out_result = {sign, 8'hFF, 23'h0}, overflow=1, inexact=1.
REQ-023 e <= 0: handled per REQ-031/032; underflow=1 iff result tiny and inexact.
REQ-024 in_sum == 0 and in_sticky == 0: out_result = {in_sign, 31'h0}, flags 0.
REQ-025 inexact = guard || sticky before rounding, or any overflow.
REQ-026 Normal case: out_result = {sign, e[7:0], mantissa}.

Reset
REQ-027 While rst high: in_ready=0, out_valid=0, out_result=0, out_flags=0, both stage valids cleared.
REQ-028 Reset mid-operation discards all in-flight data; first acceptance possible in the first cycle after rst deasserts.
REQ-029 Datapath registers other than valids need no reset except out_result/out_flags.

Configuration
REQ-030 Macro FMA_ROUND_PACK_SUBNORMAL_EN selects subnormal output support.
REQ-031 Defined: e <= 0 right-shifts mantissa (with hidden bit) by 1-e before rounding, sticky accumulating shifted-out bits; exponent field 0; round-up into bit 23 yields exponent field 1.
REQ-032 Undefined: e <= 0 flushes to {sign, 31'h0} with underflow=1, inexact=1.

Structure
REQ-033 Shared package fma_pkg holds: bias 127, binary32 field widths, flag bit indices, S1-to-S2 stage struct typedef.
REQ-034 One sub-module, fma_lzc (leading-zero counter over SUM_W bits, combinational), instantiated in S1.

Verification
REQ-035 in_exp=127, in_sum=1<<46, sticky=0, out_ready=1 -> 0x3F800000, flags 000, exactly 2 cycles after acceptance.
REQ-036 in_exp=127, in_sum=(1<<46)|(1<<22) -> 0x3F800000 (tie, even); with bit 23 also set -> 0x3F800002, inexact=1.
REQ-037 in_exp=254, in_sum=1<<48 -> 0x7F800000, flags 101; in_sign=1 -> 0xFF800000.
REQ-038 in_exp=1, in_sum=1<<45 -> 0x00400000 flags 000 with macro; 0x00000000 flags 011 without.
REQ-039 Send 4 back-to-back inputs, out_ready low 3 cycles -> in_ready drops after 2 accepted, all 4 outputs emerge in order, values held while stalled.
REQ-040 Assert rst with both stages full -> out_valid=0 next edge, no stale output after release.
